// File: rtl/noc_merge_arb_pkg.sv
// noc_pkg: shared packet widths, select encoding and the round-robin pick rule
// used by the tree-NoC merge stage.
// Contents: NOC_PKT_W / NOC_ADDR_HI / NOC_ADDR_LO, noc_pkt_t, noc_sel_t, rr_pick().
package noc_pkg;

  localparam int NOC_PKT_W   = 9;
  localparam int NOC_ADDR_HI = 8;
  localparam int NOC_ADDR_LO = 5;

  typedef logic [NOC_PKT_W-1:0] noc_pkt_t;

  typedef enum logic {SEL_IN0, SEL_IN1} noc_sel_t;

  // A lone requester wins outright; under contention the input that did not
  // win last time is chosen. With neither valid the result is don't-care.
  function automatic noc_sel_t rr_pick(input logic v0, input logic v1, input noc_sel_t last);
    if (v0 && v1) begin
      if (last == SEL_IN0) return SEL_IN1;
      else return SEL_IN0;
    end else if (v1) begin
      return SEL_IN1;
    end else begin
      return SEL_IN0;
    end
  endfunction

endpackage

// File: rtl/noc_merge_arb_fifo2.sv
// noc_fifo2: 2-entry FIFO, head entry visible combinationally on rdata.
// Latency: a push is visible on rdata the cycle after (when it lands at the head).
// Backpressure: none internally; caller must not push when full without popping,
// nor pop when empty. Ports: CLK, _RESET, push, pop, wdata, rdata, count, full, empty.
module noc_fifo2 #(
  parameter int DW = 9
) (
  input  logic          CLK,
  input  logic          _RESET,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [1:0]    count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // A push on a full FIFO always coincides with a pop, so the write lands in
  // the slot being vacated, never under the head that is still being shown.
  assign rdata = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/noc_merge_arb.sv
// noc_merge_arb: round-robin merge of two valid/ready packet streams into a
// 2-entry output buffer; optional side-band select token (macro NOC_MERGE_SEL_EN).
// Latency 1 cycle into an empty buffer; 1 packet/cycle; inputs see ready=0 when full
// and not popping. Ports: CLK, _RESET, in0_*/in1_* (data/valid/ready),
// out_data/out_valid/out_ready, and s_data/s_valid/s_ready with NOC_MERGE_SEL_EN.
module noc_merge_arb
  import noc_pkg::*;
#(
  parameter int W     = NOC_PKT_W,
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         _RESET,
  input  logic [W-1:0] in0_data,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in1_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
`ifdef NOC_MERGE_SEL_EN
  ,
  output logic         s_data,
  output logic         s_valid,
  input  logic         s_ready
`endif
);

`ifdef NOC_MERGE_SEL_EN
  localparam int EW = W + 1;
`else
  localparam int EW = W;
`endif

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  noc_sel_t      last_grant;
  noc_sel_t      sel;
  logic          any_req;
  logic          pop;
  logic          push;
  logic          space;
  logic [W-1:0]  win_data;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;
  logic [1:0]    count;
  logic          full;
  logic          empty;

  assign out_valid = !empty;
  assign out_data  = rdata[W-1:0];

`ifdef NOC_MERGE_SEL_EN
  assign s_valid = out_valid;
  assign s_data  = rdata[W];
  // Head leaves only when both the packet and its select token are taken.
  assign pop     = out_valid && out_ready && s_ready;
`else
  assign pop     = out_valid && out_ready;
`endif

  // Pop-through: a full buffer still accepts when the head leaves this cycle.
  assign space   = (count < FULL_CNT) || pop;

  assign any_req = in0_valid || in1_valid;
  assign sel     = rr_pick(in0_valid, in1_valid, last_grant);

  // Readies gated by _RESET so nothing is offered while reset is held.
  assign in0_ready = _RESET && any_req && (sel == SEL_IN0) && space;
  assign in1_ready = _RESET && any_req && (sel == SEL_IN1) && space;

  assign push     = (in0_valid && in0_ready) || (in1_valid && in1_ready);
  assign win_data = (sel == SEL_IN1) ? in1_data : in0_data;

`ifdef NOC_MERGE_SEL_EN
  assign wdata = {logic'(sel), win_data};
`else
  assign wdata = win_data;
`endif

  // Priority moves only when a packet is actually taken, so a lone requester
  // does not lose its turn at the next contention. Reset favours input 0.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      last_grant <= SEL_IN1;
    end else if (push) begin
      last_grant <= sel;
    end
  end

  noc_fifo2 #(
    .DW (EW)
  ) u_buf (
    .CLK    (CLK),
    ._RESET (_RESET),
    .push   (push),
    .pop    (pop),
    .wdata  (wdata),
    .rdata  (rdata),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  a_no_overflow: assert property (@(posedge CLK) disable iff (!_RESET) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge CLK) disable iff (!_RESET) !(pop && empty));

endmodule

// File: tb/tb_noc_merge_arb.sv
module tb_noc_merge_arb;

  logic       CLK = 1'b0;
  logic       _RESET;
  logic [8:0] in0_data, in1_data, out_data;
  logic       in0_valid, in1_valid, in0_ready, in1_ready;
  logic       out_valid, out_ready;
`ifdef NOC_MERGE_SEL_EN
  logic       s_data, s_valid, s_ready;
`endif

  always #5 CLK = ~CLK;

  noc_merge_arb dut (
    .CLK       (CLK),
    ._RESET    (_RESET),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef NOC_MERGE_SEL_EN
    ,
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Expected packets in output order: {input index, data}.
  logic [9:0] sb[$];
  // Reference state: occupancy and the input that won most recently.
  int   m_cnt;
  int   m_lg;
  bit   in_rst;
  logic a0, a1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step(input logic v0, input logic [8:0] d0, input logic v1, input logic [8:0] d1,
                      input logic ordy, input logic srdy, output logic acc0, output logic acc1);
    bit popm, spc, e0, e1;
    int win;
    in0_valid = v0; in0_data = d0;
    in1_valid = v1; in1_data = d1;
    out_ready = ordy;
`ifdef NOC_MERGE_SEL_EN
    s_ready   = srdy;
    popm = (m_cnt > 0) && ordy && srdy;
`else
    popm = (m_cnt > 0) && ordy;
`endif
    #1;
    spc = (m_cnt < 2) || popm;
    if (v0 && v1) win = 1 - m_lg;
    else if (v1)  win = 1;
    else          win = 0;
    e0 = v0 && (win == 0) && spc;
    e1 = v1 && (win == 1) && spc;
    check("in0_ready", in0_ready, e0);
    check("in1_ready", in1_ready, e1);
    acc0 = e0;
    acc1 = e1;
    @(posedge CLK);
    if (e0 || e1) begin
      sb.push_back({win[0], (e1 ? d1 : d0)});
      m_lg = win;
      m_cnt++;
    end
    if (popm) m_cnt--;
    @(negedge CLK);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_in0_ready"}, in0_ready, 0);
    check({tag, "_in1_ready"}, in1_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
`ifdef NOC_MERGE_SEL_EN
    check({tag, "_s_valid"}, s_valid, 0);
    check({tag, "_s_data"}, s_data, 0);
`endif
  endtask

  // Entered at a falling edge; asserts reset asynchronously between edges.
  task automatic do_reset();
    #3;
    in_rst = 1;
    in0_valid = 1; in1_valid = 1; out_ready = 1;
`ifdef NOC_MERGE_SEL_EN
    s_ready = 1;
`endif
    _RESET = 0;
    #1;
    reset_checks("rst_async");
    @(negedge CLK);
    #1;
    reset_checks("rst_held");
    @(negedge CLK);
    #3;
    in0_valid = 0; in1_valid = 0;
    _RESET = 1;
    sb.delete();
    m_cnt = 0;
    m_lg = 1;
    in_rst = 0;
    @(negedge CLK);
  endtask

  // Monitor: every cycle compare the presented head with the scoreboard and
  // retire it when the consumer takes it.
  always @(negedge CLK) begin
    if (!in_rst) begin
      logic [9:0] head;
      bit take;
      #2;
      check("out_valid", out_valid, sb.size() > 0);
`ifdef NOC_MERGE_SEL_EN
      check("s_valid", s_valid, out_valid);
      take = out_ready && s_ready;
`else
      take = out_ready;
`endif
      if (sb.size() > 0) begin
        head = sb[0];
        check("out_data", out_data, head[8:0]);
`ifdef NOC_MERGE_SEL_EN
        check("s_data", s_data, head[9]);
`endif
        if (take) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [8:0] d;
    logic       p0, p1;
    logic [8:0] r0, r1;
    in_rst = 1;
    _RESET = 0;
    in0_valid = 0; in1_valid = 0; in0_data = 0; in1_data = 0; out_ready = 0;
`ifdef NOC_MERGE_SEL_EN
    s_ready = 0;
`endif
    m_cnt = 0; m_lg = 1;
    @(negedge CLK);
    do_reset();

    // Single packet on input 0.
    step(1, 9'h1A5, 0, 9'h000, 1, 1, a0, a1);
    step(0, 9'h000, 0, 9'h000, 1, 1, a0, a1);

    // Continuous contention from reset: 0x021, 0x142 alternate.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 9'h021, 1, 9'h142, 1, 1, a0, a1);
    for (int i = 0; i < 3; i++) step(0, 9'h000, 0, 9'h000, 1, 1, a0, a1);

    // Fill with output stalled, then pop and push in the same cycle.
    d = 9'h0F0;
    for (int i = 0; i < 6; i++) begin
      step(0, 9'h000, d <= 9'h0F2, d, i >= 4, 1, a0, a1);
      if (a1) d = d + 9'd1;
    end
    for (int i = 0; i < 3; i++) step(0, 9'h000, 0, 9'h000, 1, 1, a0, a1);

    // Full buffer, consumer ready but select side not ready for one cycle.
    step(1, 9'h055, 0, 9'h000, 0, 1, a0, a1);
    step(1, 9'h0AA, 0, 9'h000, 0, 1, a0, a1);
    step(1, 9'h133, 0, 9'h000, 1, 0, a0, a1);
    step(1, 9'h133, 0, 9'h000, 1, 1, a0, a1);
    for (int i = 0; i < 3; i++) step(0, 9'h000, 0, 9'h000, 1, 1, a0, a1);

    // Two packets buffered, then reset mid-operation; priority restarts at input 0.
    step(0, 9'h000, 1, 9'h1E1, 0, 1, a0, a1);
    step(0, 9'h000, 1, 9'h1E2, 0, 1, a0, a1);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 9'h10C, 1, 9'h0C1, 1, 1, a0, a1);
    for (int i = 0; i < 3; i++) step(0, 9'h000, 0, 9'h000, 1, 1, a0, a1);

    // Lone requester on input 1 keeps last_grant=1, so input 0 wins next.
    for (int i = 0; i < 3; i++) step(0, 9'h000, 1, 9'(9'h0B0 + i), 1, 1, a0, a1);
    for (int i = 0; i < 3; i++) step(1, 9'h07E, 1, 9'h0E7, 1, 1, a0, a1);
    for (int i = 0; i < 3; i++) step(0, 9'h000, 0, 9'h000, 1, 1, a0, a1);

    // Random traffic; an offered packet is held until taken.
    p0 = 0; p1 = 0; r0 = 0; r1 = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!p0) begin p0 = ($urandom_range(0, 2) != 0); r0 = 9'($urandom); end
      if (!p1) begin p1 = ($urandom_range(0, 2) != 0); r1 = 9'($urandom); end
      step(p0, r0, p1, r1, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, a0, a1);
      if (a0) p0 = 0;
      if (a1) p1 = 0;
    end

    for (int i = 0; i < 6; i++) step(0, 9'h000, 0, 9'h000, 1, 1, a0, a1);
    #3;
    check("drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/noc_merge_arb.md
# noc_merge_arb

Two-input merge stage for the tree NoC. It sits directly downstream of the address decoder stages: it takes one decoder's `Out0` stream and a sibling decoder's `Out1` stream, arbitrates between them round-robin, and forwards each winning 9-bit packet through a 2-entry output buffer. It optionally emits a side-band select token naming the input that won. It is the RTL body behind the channel-conversion wrapper, so all ports are clocked valid/ready channels.

## Interface
Parameters:
- `W`, default 9: packet width; bits [8:5] are the destination address, bits [4:0] are the payload.
- `DEPTH`, default 2: output buffer entries. Only the value 2 is supported.

Ports:
- `CLK`  in  1  clock.
- `_RESET`  in  1  asynchronous, active-low reset.
- `in0_data`  in  W  input 0 packet.
- `in0_valid`  in  1  input 0 offers a packet.
- `in0_ready`  out  1  input 0 packet accepted this cycle.
- `in1_data`, `in1_valid`, `in1_ready`: same as input 0, for input 1.
- `out_data`  out  W  head-of-buffer packet.
- `out_valid`  out  1  buffer is non-empty.
- `out_ready`  in  1  consumer takes the head packet.
- `s_data`  out  1  input index of the head packet. Present only with `NOC_MERGE_SEL_EN`.
- `s_valid`  out  1  equals `out_valid`. Present only with `NOC_MERGE_SEL_EN`.
- `s_ready`  in  1  select consumer ready. Present only with `NOC_MERGE_SEL_EN`.

## Operation
- State:
  - `last_grant`: 1 bit.
  - Buffer: 2 entries, each packet plus select bit.
  - `count`: 0 to 2.
  - Read and write pointers: 1 bit each, wrapping modulo 2.
- Pop condition is `pop = out_valid && out_ready`. With `NOC_MERGE_SEL_EN` it also requires `s_ready`.
- Space condition is `space = (count < 2) || pop`. Push is allowed on a full buffer in the same cycle as a pop.
- Arbitration is combinational each cycle:
  - Only one input valid: that input is chosen.
  - Both inputs valid: the input not equal to `last_grant` is chosen.
  - Neither valid: nothing is chosen.
- The chosen input gets `inX_ready = space`; the other input gets `inX_ready = 0`.
- Push occurs when the chosen input's valid and ready are both high. On push:
  - Store `{sel, data}` at the write pointer and advance the write pointer.
  - Set `last_grant` to `sel`.
- `last_grant` changes only on push. A lone requester does not forfeit priority on later contention.
- Count update: push alone gives +1, pop alone gives -1, push and pop together leave it unchanged.
- Packet contents pass through unmodified; no address checking is done.
- Strict round-robin: with both inputs continuously valid and the output always ready, grants alternate 0,1,0,1.

## Timing
- Reset values, asynchronous on `_RESET` low:
  - `count` = 0, both pointers = 0, `last_grant` = 1, so input 0 wins the first contention.
  - `out_valid` = 0, `s_valid` = 0.
  - `out_data` = 0, `s_data` = 0.
  - `in0_ready` = 0, `in1_ready` = 0.
- Ready outputs are held 0 while `_RESET` is asserted.
- Latency: a packet pushed in cycle N appears on `out_data` with `out_valid` high in cycle N+1 if the buffer was empty.
- Throughput: 1 packet per cycle.
- Empty: `out_valid` = 0, and `out_data` holds the last read entry (not required to be 0).
- Full with `out_ready` = 0: both input readies are 0.
- Valid/ready protocol rules:
  - Input valid must stay high with data stable until accepted. The block does not check this.
  - `out_valid` and `out_data` stay stable while the output is stalled.
- Reset asserted mid-operation discards all buffered packets. After release the next accept follows the reset priority.

## Configuration
- Macro: `NOC_MERGE_SEL_EN`.
- Defined:
  - The `s_*` ports exist and buffer entries are W+1 bits wide.
  - `s_data` gives the originating input of the head packet.
  - Pop needs both `out_ready` and `s_ready`.
- Undefined:
  - The `s_*` ports are absent and entries are W bits wide.
  - Pop needs `out_ready` only.
  - Arbitration is identical in both builds.

## Structure
- Package `noc_pkg` holds:
  - `NOC_PKT_W = 9`, `NOC_ADDR_HI = 8`, `NOC_ADDR_LO = 5`.
  - `typedef logic [NOC_PKT_W-1:0] noc_pkt_t`.
  - `typedef enum logic {SEL_IN0, SEL_IN1} noc_sel_t`.
- Sub-module `noc_fifo2`: a parameterised-width 2-entry FIFO with push, pop, count, full and empty. It is instantiated once.
- The arbiter and `last_grant` register stay in the top module.

## Test plan
- Reset, then `in0` = 0x1A5 valid alone → `in0_ready` = 1; next cycle `out_data` = 0x1A5, `out_valid` = 1, `s_data` = 0.
- Both inputs valid from reset (`in0` = 0x021, `in1` = 0x142), `out_ready` = 1 → output order 0x021, 0x142, 0x021, … with `s_data` = 0,1,0,…
- `out_ready` = 0 and `in1` streams 0x0F0, 0x0F1, 0x0F2 → `count` reaches 2 and `in1_ready` = 0. When `out_ready` = 1, 0x0F0 pops and 0x0F2 is pushed in the same cycle, and `count` stays 2.
- Full buffer plus a single cycle with `out_ready` = 1 and `s_ready` = 0 (`NOC_MERGE_SEL_EN` builds) → no pop, `out_data` stable.
- Two packets buffered, then `_RESET` pulsed low → `out_valid` = 0 at once. After release with both inputs valid, `in0` is granted first.
- `in1` alone for 3 packets, then both inputs valid → `in0` is granted next, because `last_grant` = 1.
